// File: rtl/depth_line_reader.sv
// Line consumer for the depth-engine array: captures (x, depth) writes into a ping-pong
// line buffer and replays each completed line as a valid/ready pixel stream.
module depth_line_reader #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned DEPTH_WIDTH   = 10,
    localparam int unsigned XW = $clog2(SCREEN_WIDTH),
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [XW-1:0]          wr_addr,
    input  logic [DEPTH_WIDTH-1:0] wr_depth,
    input  logic                   line_done,
    output logic                   engine_start,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DEPTH_WIDTH-1:0] m_depth,
    output logic [XW-1:0]          m_x,
    output logic [YW-1:0]          m_y,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   err_wr
);

    localparam logic [XW-1:0] XMAX = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {RIdle, RPrime, RStream} rd_state_e;

    logic [DEPTH_WIDTH-1:0] mem_q [2][SCREEN_WIDTH];

    logic                   line_done_q;
    logic                   busy_q, busy_d;
    logic [1:0]             bank_full_q, bank_full_d;
    logic                   wb_q, wb_d;
    logic                   rb_q, rb_d;
    logic [YW-1:0]          wy_q, wy_d;
    logic [YW-1:0]          bank_y_q [2];
    logic                   engine_start_q;
    logic                   err_q;
    logic [DEPTH_WIDTH-1:0] rd_q;
    rd_state_e              state_q, state_d;
    logic                   m_valid_q, m_valid_d;
    logic [XW-1:0]          m_x_q, m_x_d;
    logic [YW-1:0]          m_y_q, m_y_d;
    logic                   m_sof_q, m_sof_d;
    logic                   m_eol_q, m_eol_d;

    logic          addr_ok;
    logic          wr_ok;
    logic          wr_bad;
    logic          line_close;
    logic          release_bank;
    logic          start_go;
    logic          rd_en;
    logic [XW-1:0] rd_addr;

    always_comb begin
        addr_ok    = (32'(wr_addr) < SCREEN_WIDTH);
        wr_ok      = wr_en && busy_q && addr_ok;
        wr_bad     = wr_en && (!busy_q || !addr_ok);
        line_close = line_done && !line_done_q && busy_q;
    end

    // Read side: the memory output register doubles as the m_depth register, so a read
    // issued in a handshake cycle lands exactly when the next beat is presented.
    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        rd_addr      = '0;
        release_bank = 1'b0;
        m_valid_d    = m_valid_q;
        m_x_d        = m_x_q;
        m_y_d        = m_y_q;
        m_sof_d      = m_sof_q;
        m_eol_d      = m_eol_q;
        unique case (state_q)
            RIdle: begin
                if (bank_full_q[rb_q]) begin
                    rd_en   = 1'b1;
                    state_d = RPrime;
                end
            end
            RPrime: begin
                m_valid_d = 1'b1;
                m_x_d     = '0;
                m_y_d     = bank_y_q[rb_q];
                m_sof_d   = (bank_y_q[rb_q] == '0);
                m_eol_d   = (XMAX == '0);
                state_d   = RStream;
            end
            RStream: begin
                if (m_valid_q && m_ready) begin
                    if (m_x_q != XMAX) begin
                        rd_en   = 1'b1;
                        rd_addr = m_x_q + XW'(1);
                        m_x_d   = rd_addr;
                        m_sof_d = 1'b0;
                        m_eol_d = (rd_addr == XMAX);
                    end else begin
                        m_valid_d    = 1'b0;
                        release_bank = 1'b1;
                        state_d      = RIdle;
                    end
                end
            end
            default: state_d = RIdle;
        endcase
    end

    // Start is decided on next-state bank status so a release or line close can
    // restart the engine in the very next cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        busy_d      = busy_q;
        wy_d        = wy_q;
        if (release_bank) begin
            bank_full_d[rb_q] = 1'b0;
            rb_d              = ~rb_q;
        end
        if (line_close) begin
            bank_full_d[wb_q] = 1'b1;
            wb_d              = ~wb_q;
            busy_d            = 1'b0;
            wy_d              = (wy_q == YMAX) ? '0 : wy_q + YW'(1);
        end
        start_go = !busy_d && !bank_full_d[wb_d];
        if (start_go) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wb_q][wr_addr] <= wr_depth;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            bank_full_q    <= 2'b00;
            wb_q           <= 1'b0;
            rb_q           <= 1'b0;
            wy_q           <= '0;
            bank_y_q[0]    <= '0;
            bank_y_q[1]    <= '0;
            engine_start_q <= 1'b0;
            err_q          <= 1'b0;
            rd_q           <= '0;
            state_q        <= RIdle;
            m_valid_q      <= 1'b0;
            m_x_q          <= '0;
            m_y_q          <= '0;
            m_sof_q        <= 1'b0;
            m_eol_q        <= 1'b0;
        end else begin
            line_done_q    <= line_done;
            busy_q         <= busy_d;
            bank_full_q    <= bank_full_d;
            wb_q           <= wb_d;
            rb_q           <= rb_d;
            wy_q           <= wy_d;
            engine_start_q <= start_go;
            if (line_close) begin
                bank_y_q[wb_q] <= wy_q;
            end
            if (wr_bad) begin
                err_q <= 1'b1;
            end
            if (rd_en) begin
                rd_q <= mem_q[rb_q][rd_addr];
            end
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_x_q     <= m_x_d;
            m_y_q     <= m_y_d;
            m_sof_q   <= m_sof_d;
            m_eol_q   <= m_eol_d;
        end
    end

    assign engine_start = engine_start_q;
    assign err_wr       = err_q;
    assign m_valid      = m_valid_q;
    assign m_depth      = rd_q;
    assign m_x          = m_x_q;
    assign m_y          = m_y_q;
    assign m_sof        = m_sof_q;
    assign m_eol        = m_eol_q;

endmodule

// File: tb/tb_depth_line_reader.sv
// Bench for depth_line_reader: a line-level engine model writes random lines and a FIFO of
// expected pixels is checked against every handshake; timing points are checked directly.
module tb_depth_line_reader;

    // Width 6 keeps XW = 3, so x = 6 and 7 are representable out-of-range addresses.
    localparam int W  = 6;
    localparam int H  = 4;
    localparam int DW = 10;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    typedef struct packed {
        logic [DW-1:0] depth;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
    } pix_t;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [XW-1:0] wr_addr;
    logic [DW-1:0] wr_depth;
    logic          line_done;
    logic          engine_start;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_depth;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic          m_sof;
    logic          m_eol;
    logic          err_wr;

    depth_line_reader #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .DEPTH_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_depth    (wr_depth),
        .line_done   (line_done),
        .engine_start(engine_start),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_depth     (m_depth),
        .m_x         (m_x),
        .m_y         (m_y),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .err_wr      (err_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_start = 0;
    int starts_used = 0;
    int start_cyc = -1;
    int eol_mark = -1;
    int ready_mode = 3;  // 0: always, 1: 1,0,0 pattern, 2: random, 3: held low
    int ready_ph = 0;
    int wy_model = 0;
    pix_t exp_q[$];
    logic [DW-1:0] line_buf [W];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        pix_t pre, cur, e;
        logic pre_v, hs;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin m_ready = (ready_ph % 3 == 0); ready_ph++; end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        pre   = {m_depth, m_x, m_y, m_sof, m_eol};
        pre_v = m_valid;
        hs    = m_valid && m_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (engine_start) begin
            n_start++;
            start_cyc = cyc;
        end
        cur = {m_depth, m_x, m_y, m_sof, m_eol};
        if (hs) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat", pre, e);
                if (e.eol && eol_mark < 0) eol_mark = cyc - 1;
            end
        end else if (pre_v) begin
            chk("stall_hold", {m_valid, cur}, {1'b1, pre});
        end
    endtask

    task automatic wait_start();
        int k = 0;
        while (n_start <= starts_used && k < 200) begin
            tick();
            k++;
        end
        chk("start_seen", n_start > starts_used, 1);
        starts_used++;
    endtask

    // mode 0: ramp depth 10+x in order; mode 1: random depths, reverse order, random overwrites
    task automatic write_line(input int mode);
        int x;
        logic [DW-1:0] d;
        for (int i = 0; i < W + 3 * mode; i++) begin
            if (mode == 0) begin
                x = i;
                d = DW'(10 + i);
            end else begin
                x = (i < W) ? W - 1 - i : int'($urandom_range(0, W - 1));
                d = DW'($urandom_range(0, (1 << DW) - 1));
            end
            wr_en    = 1'b1;
            wr_addr  = XW'(x);
            wr_depth = d;
            line_buf[x] = d;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic push_line();
        for (int x = 0; x < W; x++) begin
            exp_q.push_back({line_buf[x], XW'(x), YW'(wy_model), (x == 0 && wy_model == 0),
                             (x == W - 1)});
        end
        wy_model = (wy_model + 1) % H;
    endtask

    task automatic end_line();
        push_line();
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        tick();
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 400) begin
            tick();
            k++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        int s0;
        int k;
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_depth  = '0;
        line_done = 1'b0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {engine_start, m_valid, m_depth, m_x, m_y, m_sof, m_eol, err_wr}, 0);

        // First start pulse on the first edge after release, one cycle wide.
        reset_n = 1'b1;
        cyc = 0;
        tick();
        chk("start_cycle1", engine_start, 1);
        tick();
        chk("start_one_cycle", engine_start, 0);
        chk("err_clear", err_wr, 0);

        // Single line, ramp data, full throughput.
        ready_mode = 0;
        wait_start();
        write_line(0);
        push_line();
        line_done = 1'b1;
        tick();
        chk("restart_after_close", engine_start, 1);
        line_done = 1'b0;
        tick();
        chk("valid_t2", m_valid, 0);
        tick();
        chk("valid_t3", m_valid, 1);
        c0 = cyc;
        drain();
        chk("line_beats_back_to_back", cyc - c0, W);
        chk("valid_drop", m_valid, 0);

        // Backpressure 1,0,0.
        ready_mode = 1;
        ready_ph = 0;
        wait_start();
        write_line(1);
        end_line();
        drain();

        // Both banks full, then release timing.
        ready_mode = 3;
        wait_start();
        write_line(1);
        end_line();
        wait_start();
        write_line(1);
        end_line();
        s0 = n_start;
        repeat (20) tick();
        chk("no_start_both_full", n_start, s0);
        chk("no_start_outstanding", n_start - starts_used, 0);
        chk("err_before_illegal", err_wr, 0);

        // Write while idle is dropped and flagged; line_done while idle is ignored.
        wr_en    = 1'b1;
        wr_addr  = XW'(2);
        wr_depth = ~line_buf[2];
        tick();
        wr_en = 1'b0;
        tick();
        chk("err_idle_write", err_wr, 1);
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        tick();

        ready_mode = 0;
        eol_mark = -1;
        wait_start();
        chk("start_after_release", start_cyc, eol_mark + 1);

        // Out-of-range address while busy.
        wr_en    = 1'b1;
        wr_addr  = XW'(7);
        wr_depth = DW'(5);
        tick();
        wr_en = 1'b0;
        write_line(1);
        end_line();
        chk("err_sticky", err_wr, 1);
        drain();

        // Random-ready run across several frame wraps.
        ready_mode = 2;
        for (int n = 0; n < 5; n++) begin
            wait_start();
            write_line(1);
            end_line();
        end
        drain();

        // Reset while beat 3 is on the bus.
        ready_mode = 0;
        wait_start();
        write_line(1);
        end_line();
        k = 0;
        while (!(m_valid && m_x == XW'(3)) && k < 30) begin
            tick();
            k++;
        end
        chk("beat3_reached", m_valid && m_x == XW'(3), 1);
        reset_n = 1'b0;
        #1;
        chk("reset_midstream", {engine_start, m_valid, m_depth, m_x, m_y, m_sof, m_eol, err_wr},
            0);
        exp_q.delete();
        n_start = 0;
        starts_used = 0;
        wy_model = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        tick();
        chk("start_after_reset", engine_start, 1);
        ready_mode = 2;
        wait_start();
        write_line(1);
        end_line();
        drain();
        chk("err_after_reset", err_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
